// File: rtl/proc_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : proc_ctrl_pkg
// Purpose  : Shared encodings for the frame sequencer. It holds the FSM state
//            codes, the register indices, the CTRL/STATUS bit positions and
//            the datapath mode codes.
// Revision : 1.0 - initial release
// ============================================================================
package proc_ctrl_pkg;

  // Frame sequencer states
  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_RUN   = 2'd1;
  localparam logic [1:0] C_ST_DRAIN = 2'd2;
  localparam logic [1:0] C_ST_DONE  = 2'd3;

  // Register indices on cfg_addr
  localparam logic [1:0] C_REG_CTRL      = 2'd0;
  localparam logic [1:0] C_REG_FRAME_LEN = 2'd1;
  localparam logic [1:0] C_REG_STATUS    = 2'd2;
  localparam logic [1:0] C_REG_OUT_COUNT = 2'd3;

  // CTRL bit positions
  localparam int C_CTRL_START   = 0;
  localparam int C_CTRL_ABORT   = 1;
  localparam int C_CTRL_MODE_LO = 2;
  localparam int C_CTRL_MODE_HI = 3;

  // STATUS bit positions
  localparam int C_STAT_BUSY      = 0;
  localparam int C_STAT_DONE      = 1;
  localparam int C_STAT_START_ERR = 2;
  localparam int C_STAT_ABORTED   = 3;

  // Datapath mode codes driven on proc_cont
  typedef logic [1:0] mode_t;
  localparam mode_t C_MODE_PASS    = 2'd0;
  localparam mode_t C_MODE_INVERT  = 2'd1;
  localparam mode_t C_MODE_LAPLACE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/proc_frame_ctrl_px_counter.sv
`default_nettype none
// ============================================================================
// Module   : px_counter
// Purpose  : Saturating pixel counter with a synchronous clear.
// Ports    : clk, rstn      - clock, synchronous active-low reset
//            clr            - clear to zero (has priority over inc)
//            inc            - count one pixel (ignored once at the limit)
//            limit          - saturation value
//            count          - current value
//            at_limit       - count has reached limit
//            hit_next       - this cycle's increment makes count == limit
// Revision : 1.0 - initial release
// ============================================================================
module px_counter #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit,
  output logic             hit_next
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] w_count_inc;

  assign w_count_inc = count_q + CNT_W'(1);
  // >= keeps the counter frozen even if limit is lowered below the count
  assign at_limit    = (count_q >= limit);
  assign hit_next    = inc & ~at_limit & (w_count_inc == limit);
  assign count       = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_limit) begin
      count_d = w_count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/proc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : proc_frame_ctrl
// Purpose  : Frame-level sequencer for the 3x3 pixel datapath. It programs
//            the filter mode and gates exactly FRAME_LEN pixels from the
//            source into the datapath. It counts results handed to the sink
//            and raises done/irq when the frame is complete.
// Ports    : clk, rstn                - clock, synchronous active-low reset
//            cfg_we/addr/wdata/rdata  - register port (CTRL, FRAME_LEN,
//                                       STATUS, OUT_COUNT)
//            src_*                    - upstream pixel stream
//            proc_pixel_in/valid_in, proc_ready_out - into the datapath
//            proc_pixel_out/valid_out, proc_ready_in - out of the datapath
//            proc_cont                - datapath mode select
//            sink_*                   - downstream result stream
//            irq                      - one-cycle frame-complete pulse
// Revision : 1.0 - initial release
// ============================================================================
module proc_frame_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 1024,
  parameter int CNT_W      = 21
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic [7:0]  proc_pixel_in,
  output logic        proc_valid_in,
  input  logic        proc_ready_out,
  output logic [1:0]  proc_cont,
  input  logic [7:0]  proc_pixel_out,
  input  logic        proc_valid_out,
  output logic        proc_ready_in,
  output logic [7:0]  sink_data,
  output logic        sink_valid,
  input  logic        sink_ready,
  output logic        irq
);

  localparam logic [CNT_W-1:0] C_FRAME_LEN_RST = CNT_W'(IMG_WIDTH * IMG_HEIGHT);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       proc_cont_q, proc_cont_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic             done_q, done_d;
  logic             start_err_q, start_err_d;
  logic             aborted_q, aborted_d;

  logic [CNT_W-1:0] w_in_cnt, w_out_cnt;
  logic             w_in_at_limit, w_in_hit_next;
  logic             w_out_at_limit, w_out_hit_unused;

  logic w_wr_ctrl, w_wr_len, w_wr_stat;
  logic w_start_wr, w_abort_wr;
  logic w_run, w_active, w_idle, w_done_st;
  logic w_frame_start, w_abort_eff;
  logic w_in_xfer, w_out_xfer;

  // ---------------------------------------------------------------- decode
  assign w_wr_ctrl  = cfg_we & (cfg_addr == C_REG_CTRL);
  assign w_wr_len   = cfg_we & (cfg_addr == C_REG_FRAME_LEN);
  assign w_wr_stat  = cfg_we & (cfg_addr == C_REG_STATUS);
  assign w_abort_wr = w_wr_ctrl & cfg_wdata[C_CTRL_ABORT];
  // A simultaneous start+abort is treated purely as an abort
  assign w_start_wr = w_wr_ctrl & cfg_wdata[C_CTRL_START] & ~cfg_wdata[C_CTRL_ABORT];

  assign w_idle    = (state_q == C_ST_IDLE);
  assign w_run     = (state_q == C_ST_RUN);
  assign w_done_st = (state_q == C_ST_DONE);
  assign w_active  = w_run | (state_q == C_ST_DRAIN);

  assign w_frame_start = w_idle & w_start_wr;
  assign w_abort_eff   = w_abort_wr & ~w_idle;

  // -------------------------------------------------------------- handshakes
  assign proc_pixel_in = src_data;
  assign proc_valid_in = w_run & src_valid & ~w_in_at_limit;
  assign src_ready     = w_run & proc_ready_out & ~w_in_at_limit;
  assign sink_data     = proc_pixel_out;
  assign sink_valid    = w_active & proc_valid_out;
  assign proc_ready_in = w_active & sink_ready;
  assign proc_cont     = proc_cont_q;
  // An abort landing in the DONE cycle suppresses the completion pulse
  assign irq           = w_done_st & ~w_abort_wr;

  assign w_in_xfer  = proc_valid_in & proc_ready_out;
  assign w_out_xfer = w_active & proc_valid_out & sink_ready;

  // ---------------------------------------------------------------- counters
  px_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (w_frame_start),
    .inc      (w_in_xfer),
    .limit    (frame_len_q),
    .count    (w_in_cnt),
    .at_limit (w_in_at_limit),
    .hit_next (w_in_hit_next)
  );

  px_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (w_frame_start),
    .inc      (w_out_xfer),
    .limit    (frame_len_q),
    .count    (w_out_cnt),
    .at_limit (w_out_at_limit),
    .hit_next (w_out_hit_unused)
  );

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE:  if (w_start_wr) state_d = (frame_len_q == '0) ? C_ST_DONE : C_ST_RUN;
      C_ST_RUN:   if (w_in_hit_next) state_d = C_ST_DRAIN;
      C_ST_DRAIN: if (w_out_at_limit) state_d = C_ST_DONE;
      C_ST_DONE:  state_d = C_ST_IDLE;
      default:    state_d = C_ST_IDLE;
    endcase
    if (w_abort_eff) state_d = C_ST_IDLE;
  end

  always_comb begin
    mode_d      = w_wr_ctrl ? cfg_wdata[C_CTRL_MODE_HI:C_CTRL_MODE_LO] : mode_q;
    // The mode written alongside start takes effect for that frame
    proc_cont_d = w_frame_start ? mode_d : proc_cont_q;
    frame_len_d = (w_wr_len && !w_active) ? cfg_wdata[CNT_W-1:0] : frame_len_q;
    // Sticky flags: a set in the same cycle as a W1C wins
    done_d      = (w_done_st & ~w_abort_wr) |
                  (done_q & ~(w_wr_stat & cfg_wdata[C_STAT_DONE]));
    start_err_d = (w_active & w_start_wr) |
                  (start_err_q & ~(w_wr_stat & cfg_wdata[C_STAT_START_ERR]));
    aborted_d   = w_abort_eff |
                  (aborted_q & ~(w_wr_stat & cfg_wdata[C_STAT_ABORTED]));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= C_ST_IDLE;
      mode_q      <= C_MODE_PASS;
      proc_cont_q <= C_MODE_PASS;
      frame_len_q <= C_FRAME_LEN_RST;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      proc_cont_q <= proc_cont_d;
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      aborted_q   <= aborted_d;
    end
  end

  // --------------------------------------------------------------- readback
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      C_REG_CTRL:      cfg_rdata[C_CTRL_MODE_HI:C_CTRL_MODE_LO] = mode_q;
      C_REG_FRAME_LEN: cfg_rdata = 32'(frame_len_q);
      C_REG_STATUS:    cfg_rdata[3:0] = {aborted_q, start_err_q, done_q, w_active};
      C_REG_OUT_COUNT: cfg_rdata = 32'(w_out_cnt);
      default:         cfg_rdata = '0;
    endcase
  end

  // FRAME_LEN bits above CNT_W are dropped on write
  generate
    if (CNT_W < 32) begin : g_wdata_unused
      logic w_unused_wdata;
      assign w_unused_wdata = ^cfg_wdata[31:CNT_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/proc_frame_ctrl.md
Name: proc_frame_ctrl

Overview:
- Frame-level sequencer for the 3x3 pixel processing datapath: programs the filter mode, gates the upstream pixel stream into the datapath for exactly FRAME_LEN pixels, and counts results leaving it.
- Raises done and irq once every output pixel of the frame has been accepted by the sink.
- Sits between the bus register block and the datapath's valid/ready ports.

Parameters:
- IMG_WIDTH, 1024, pixels per line; used only for the FRAME_LEN reset value.
- IMG_HEIGHT, 1024, lines per frame; used only for the FRAME_LEN reset value.
- CNT_W, 21, width of FRAME_LEN and both pixel counters; must hold IMG_WIDTH*IMG_HEIGHT.

Ports:
- clk  in  1  sole clock.
- rstn  in  1  synchronous, active-low reset.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register index: 0 CTRL, 1 FRAME_LEN, 2 STATUS, 3 OUT_COUNT.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  combinational read of the register at cfg_addr.
- src_valid  in  1  upstream pixel valid.
- src_data  in  8  upstream pixel.
- src_ready  out  1  upstream ready.
- proc_pixel_in  out  8  pixel to the datapath.
- proc_valid_in  out  1  valid to the datapath.
- proc_ready_out  in  1  datapath ready to accept.
- proc_cont  out  2  datapath mode select (0 pass, 1 invert, 2 Laplacian).
- proc_pixel_out  in  8  datapath result.
- proc_valid_out  in  1  datapath result valid.
- proc_ready_in  out  1  ready to the datapath.
- sink_data  out  8  result to downstream.
- sink_valid  out  1  result valid to downstream.
- sink_ready  in  1  downstream ready.
- irq  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset values: state IDLE; proc_cont=0; FRAME_LEN=IMG_WIDTH*IMG_HEIGHT; mode register=0; in_cnt=0; out_cnt=0; all STATUS bits 0; irq=0. All valid/ready outputs are 0 in IDLE.
- CTRL register: bit0 start (write-1 pulse, reads 0); bit1 abort (write-1 pulse, reads 0); bits[3:2] mode (read/write).
- STATUS register: bit0 busy (RUN or DRAIN); bit1 done (sticky, write-1-to-clear); bit2 start_err (sticky, W1C); bit3 aborted (sticky, W1C).
- OUT_COUNT register: reads out_cnt; read-only.
- IDLE → RUN: start written in cycle N; state is RUN at N+1.
  - At the transition, proc_cont is loaded from mode and in_cnt/out_cnt are cleared.
  - proc_cont is held constant until the next start; mode writes while busy change only the register.
- IDLE with FRAME_LEN==0: start goes straight to DONE; no pixels move.
- RUN, input path:
  - proc_valid_in = src_valid & (in_cnt<FRAME_LEN).
  - src_ready = proc_ready_out & (in_cnt<FRAME_LEN).
  - proc_pixel_in = src_data (combinational).
  - An input transfer is proc_valid_in & proc_ready_out; it increments in_cnt.
- RUN/DRAIN, output path:
  - sink_data = proc_pixel_out; sink_valid = proc_valid_out; proc_ready_in = sink_ready.
  - An output transfer is proc_valid_out & sink_ready; it increments out_cnt, saturating at FRAME_LEN.
- RUN → DRAIN: in the cycle after the transfer that makes in_cnt == FRAME_LEN.
- DRAIN → DONE: when out_cnt == FRAME_LEN.
  - Output transfers may occur during RUN; if out_cnt already equals FRAME_LEN on entry to DRAIN, DRAIN lasts exactly one cycle.
- DONE: lasts one cycle. Sets done, drives irq=1, then returns to IDLE. Output path is gated off.
- Start while busy: ignored and sets start_err. A simultaneous start and abort resolves as abort.
- Abort in RUN/DRAIN/DONE:
  - Next cycle is IDLE, all handshakes are deasserted, and aborted is set.
  - Counters keep their values; done is not set and irq does not pulse.
  - Abort in IDLE has no effect.
- FRAME_LEN writes while busy are ignored. The width is CNT_W and the upper cfg_wdata bits are dropped.
- W1C of done in the same cycle DONE sets it: set wins.
- rstn low in any state: next cycle equals the reset values, regardless of in-flight handshakes.

Decomposition:
- Shared package proc_ctrl_pkg:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - register index constants (CTRL, FRAME_LEN, STATUS, OUT_COUNT);
  - CTRL and STATUS bit positions;
  - mode codes for pass, invert and Laplacian.
- One sub-module, px_counter: CNT_W-wide counter with clear, increment enable, a saturation limit and an at_limit flag. It is instantiated twice, for in_cnt and out_cnt.

Test Plan:
- FRAME_LEN=4, mode=1, src 0x10,0x20,0x30,0x40 with proc/sink always ready → proc_cont=1 from start+1; exactly 4 input transfers; src_ready low after the 4th; done=1; one irq pulse; OUT_COUNT=4.
- FRAME_LEN=3 with sink_ready low for 5 cycles after the 3rd input → state held in DRAIN; irq fires only after the 3rd output transfer; busy=1 throughout.
- Write start during RUN → start_err=1; frame completes normally. Then write mode=2 during RUN → proc_cont unchanged until the next start.
- Abort after 2 of 8 inputs → IDLE next cycle; src_ready=0; aborted=1; done=0; no irq; OUT_COUNT keeps its value.
- FRAME_LEN=0 then start → DONE after 1 cycle, irq pulse, no handshakes asserted. Separately, rstn low mid-RUN → all outputs at reset values on the next cycle, FRAME_LEN=1048576.
